// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multdiv divider.
// Widths, FSM state encoding and the signed overflow operand.
package multdiv_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    localparam logic [DIV_WIDTH-1:0] MOST_NEG =
        {1'b1, {(DIV_WIDTH-1){1'b0}}};

endpackage

// File: rtl/multdiv_divider_if.sv
// Start/operand/result bundle between execute control and the divider.
// DIV_REMAINDER_EN adds the signed remainder output.
interface multdiv_divider_if #(
    parameter int WIDTH = 32
);

    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;
`endif

    modport master (
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
        input  data_resultRDY,
        input  busy
`ifdef DIV_REMAINDER_EN
        , input data_remainder
`endif
    );

    modport slave (
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
        output data_resultRDY,
        output busy
`ifdef DIV_REMAINDER_EN
        , output data_remainder
`endif
    );

endinterface

// File: rtl/div_step.sv
// One restoring division iteration on unsigned magnitudes.
// Shifts the dividend MSB into the partial remainder and subtracts if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        fits     = shifted >= {1'b0, dvs};
        // partial remainder stays below the divisor, so the low bits hold the difference
        diff     = shifted[WIDTH-1:0] - dvs;
        rem_next = fits ? diff : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/multdiv_divider.sv
// Iterative signed restoring divider, one quotient bit per cycle.
// Optional remainder output when DIV_REMAINDER_EN is defined.
module multdiv_divider
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input logic             clk,
    input logic             clr,
    multdiv_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_state_t       state_next;
    logic [CW-1:0]    counter;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             sign_q;
    logic             ovf;
    logic             dz;
    logic [WIDTH-1:0] result;
    logic             exception;
    logic             rdy;
    logic             running;

    logic             start;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             b_zero;
    logic             is_ovf;

    always_comb begin
        start  = bus.ctrl_DIV;
        a_abs  = bus.data_operandA[WIDTH-1] ? -bus.data_operandA
                                            : bus.data_operandA;
        b_abs  = bus.data_operandB[WIDTH-1] ? -bus.data_operandB
                                            : bus.data_operandB;
        b_zero = bus.data_operandB == '0;
        is_ovf = (bus.data_operandA == MIN_VAL) && (bus.data_operandB == '1);
    end

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem      (rem_acc),
        .quo      (quo_acc),
        .dvs      (dvs_abs),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // a zero divisor parks in IDLE for one cycle with dz set, then reports
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = b_zero ? IDLE : RUN;
        end else begin
            unique case (state)
                IDLE: if (dz) state_next = DONE;
                RUN:  if (counter == LAST) state_next = DONE;
                DONE: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        running = state == RUN;
        rdy     = state == DONE;
    end

`ifdef DIV_REMAINDER_EN
    logic             sign_r;
    logic [WIDTH-1:0] remainder;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            counter   <= '0;
            rem_acc   <= '0;
            quo_acc   <= '0;
            dvs_abs   <= '0;
            sign_q    <= 1'b0;
            ovf       <= 1'b0;
            dz        <= 1'b0;
            result    <= '0;
            exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
            sign_r    <= 1'b0;
            remainder <= '0;
`endif
        end else if (start) begin
            counter <= '0;
            // zero divisor preloads |A| so the remainder comes back as A
            rem_acc <= b_zero ? a_abs : '0;
            quo_acc <= a_abs;
            dvs_abs <= b_abs;
            sign_q  <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            ovf     <= is_ovf;
            dz      <= b_zero;
`ifdef DIV_REMAINDER_EN
            sign_r  <= bus.data_operandA[WIDTH-1];
`endif
        end else begin
            dz <= 1'b0;
            if (running && counter != LAST) begin
                rem_acc <= rem_step;
                quo_acc <= quo_step;
                counter <= counter + 1'b1;
            end
            if (state_next == DONE) begin
                result    <= dz ? '0 : (sign_q ? -quo_acc : quo_acc);
                exception <= dz | ovf;
`ifdef DIV_REMAINDER_EN
                remainder <= sign_r ? -rem_acc : rem_acc;
`endif
            end
        end
    end

    assign bus.data_result    = result;
    assign bus.data_exception = exception;
    assign bus.data_resultRDY = rdy;
    assign bus.busy           = running;
`ifdef DIV_REMAINDER_EN
    assign bus.data_remainder = remainder;
`endif

endmodule

// File: tb/tb_multdiv_divider.sv
// Randomised and directed bench for multdiv_divider against an arithmetic model.
// Define DIV_REMAINDER_EN to also check the remainder output.
module tb_multdiv_divider;
    import multdiv_pkg::*;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;

    multdiv_divider_if #(.WIDTH(32)) bus ();

    multdiv_divider #(.WIDTH(32)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] q,
        output logic        exc,
        output logic [31:0] r
    );
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = 32'd0; exc = 1'b1; r = a;
        end else if (a == MOST_NEG && b == 32'hFFFF_FFFF) begin
            q = MOST_NEG; exc = 1'b1; r = 32'd0;
        end else begin
            q = 32'(sa / sb); exc = 1'b0; r = 32'(sa % sb);
        end
    endfunction

    function automatic logic [31:0] get_rem();
`ifdef DIV_REMAINDER_EN
        return bus.data_remainder;
`else
        return 32'd0;
`endif
    endfunction

    task automatic do_div(
        input  logic [31:0] a,
        input  logic [31:0] b,
        output int          lat,
        output logic [31:0] q,
        output logic        exc,
        output logic [31:0] r,
        output logic        busy_seen,
        output logic        rdy_after
    );
        bus.ctrl_DIV      = 1'b1;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clk); #1;
        bus.ctrl_DIV = 1'b0;
        lat = -1; q = '0; exc = 1'b0; r = '0; busy_seen = 1'b0; rdy_after = 1'b0;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            if (bus.busy) busy_seen = 1'b1;
            @(posedge clk); #1;
            if (bus.data_resultRDY) begin
                lat = i; q = bus.data_result; exc = bus.data_exception; r = get_rem();
            end
        end
        if (lat >= 0) begin
            @(posedge clk); #1;
            rdy_after = bus.data_resultRDY;
        end
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                            input int want_lat);
        int          lat;
        logic [31:0] q, r, eq, er;
        logic        exc, eexc, bs, ra;
        ref_div(a, b, eq, eexc, er);
        do_div(a, b, lat, q, exc, r, bs, ra);
        n_cmp++;
        if (lat !== want_lat) begin
            n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, want_lat);
        end
        n_cmp++;
        if (q !== eq) begin
            n_err++; $display("FAIL %s result %h/%h: got %h want %h", name, a, b, q, eq);
        end
        n_cmp++;
        if (exc !== eexc) begin
            n_err++; $display("FAIL %s exception: got %b want %b", name, exc, eexc);
        end
        n_cmp++;
        if (ra !== 1'b0) begin
            n_err++; $display("FAIL %s rdy width: got %b want 0", name, ra);
        end
        n_cmp++;
        if (bs !== (b != 0)) begin
            n_err++; $display("FAIL %s busy seen: got %b want %b", name, bs, b != 0);
        end
`ifdef DIV_REMAINDER_EN
        n_cmp++;
        if (r !== er) begin
            n_err++; $display("FAIL %s remainder: got %h want %h", name, r, er);
        end
`else
        if (r !== 32'd0 && er === 32'd0) $display("note: remainder disabled");
`endif
    endtask

    task automatic test_reset();
        clr = 1'b1;
        bus.ctrl_DIV = 1'b0; bus.data_operandA = '0; bus.data_operandB = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy} !== 35'd0) begin
            n_err++;
            $display("FAIL reset outputs: got %h/%b/%b/%b want 0", bus.data_result,
                     bus.data_exception, bus.data_resultRDY, bus.busy);
        end
        clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        check_op("100/7", 32'd100, 32'd7, 33);
        check_op("-100/7", -32'sd100, 32'd7, 33);
        check_op("100/-7", 32'd100, -32'sd7, 33);
        check_op("ovf", MOST_NEG, 32'hFFFF_FFFF, 33);
        check_op("minneg/1", MOST_NEG, 32'd1, 33);
        check_op("0/5", 32'd0, 32'd5, 33);
    endtask

    task automatic test_div_zero();
        check_op("5/0", 32'd5, 32'd0, 1);
        check_op("minneg/0", MOST_NEG, 32'd0, 1);
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            unique case (i % 4)
                0: b = $urandom_range(1, 1000);
                1: b = -$urandom_range(1, 1000);
                2: b = $urandom;
                default: b = (i == 11) ? 32'd0 : $urandom_range(1, 1 << 16);
            endcase
            if (i % 6 == 5) a = $urandom_range(0, 50);
            check_op("random", a, b, (b == 0) ? 1 : 33);
        end
    endtask

    task automatic test_hold();
        logic [31:0] q0;
        check_op("hold op", 32'd1000, 32'd9, 33);
        q0 = 32'd111;
        repeat (5) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.data_result !== q0 || bus.data_resultRDY !== 1'b0) begin
            n_err++; $display("FAIL hold: got %h rdy %b want %h rdy 0",
                              bus.data_result, bus.data_resultRDY, q0);
        end
    endtask

    task automatic test_restart();
        int pulses;
        int lat;
        pulses = 0; lat = -1;
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd100; bus.data_operandB = 32'd7;
        @(posedge clk); #1;
        bus.ctrl_DIV = 1'b0;
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.data_resultRDY) pulses++;
        end
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd81; bus.data_operandB = 32'd9;
        @(posedge clk); #1;
        bus.ctrl_DIV = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (bus.data_resultRDY) begin
                pulses++;
                if (lat < 0) lat = i;
                n_cmp++;
                if (bus.data_result !== 32'd9) begin
                    n_err++; $display("FAIL restart result: got %0d want 9", bus.data_result);
                end
            end
        end
        n_cmp++;
        if (pulses !== 1 || lat !== 33) begin
            n_err++; $display("FAIL restart rdy: got %0d pulses lat %0d want 1 lat 33",
                              pulses, lat);
        end
    endtask

    task automatic test_done_start();
        int lat;
        logic old_rdy;
        lat = -1; old_rdy = 1'b0;
        bus.ctrl_DIV = 1'b1; bus.data_operandA = -32'sd50; bus.data_operandB = 32'd6;
        @(posedge clk); #1;
        bus.ctrl_DIV = 1'b0;
        for (int i = 1; i <= 40 && !old_rdy; i++) begin
            @(posedge clk); #1;
            old_rdy = bus.data_resultRDY;
        end
        n_cmp++;
        if (!old_rdy || bus.data_result !== -32'sd8) begin
            n_err++; $display("FAIL done-start first: got rdy %b res %h want 1 fffffff8",
                              old_rdy, bus.data_result);
        end
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd77; bus.data_operandB = 32'd7;
        @(posedge clk); #1;
        bus.ctrl_DIV = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.data_resultRDY !== 1'b0) begin
            n_err++; $display("FAIL done-start run: got busy %b rdy %b want 1 0",
                              bus.busy, bus.data_resultRDY);
        end
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            @(posedge clk); #1;
            if (bus.data_resultRDY) lat = i;
        end
        n_cmp++;
        if (lat !== 33 || bus.data_result !== 32'd11) begin
            n_err++; $display("FAIL done-start second: got lat %0d res %0d want 33 11",
                              lat, bus.data_result);
        end
    endtask

    task automatic test_clr();
        int pulses;
        pulses = 0;
        bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd100; bus.data_operandB = 32'd7;
        @(posedge clk); #1;
        bus.ctrl_DIV = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        n_cmp++;
        if ({bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy} !== 35'd0) begin
            n_err++; $display("FAIL clr abort: got %h/%b/%b/%b want 0", bus.data_result,
                              bus.data_exception, bus.data_resultRDY, bus.busy);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.data_resultRDY) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_err++; $display("FAIL clr no rdy: got %0d pulses want 0", pulses);
        end
        check_op("6/3 after clr", 32'd6, 32'd3, 33);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_div_zero();
        test_random();
        test_hold();
        test_restart();
        test_done_start();
        test_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
